keypad_digit_entry: RTL and testbench
=====================================

Name: keypad_digit_entry

Overview:
Upstream stage of the microwave controller. Debounces the 10-bit one-hot keypad and encodes each accepted press to BCD. Shifts the digit into a 3-digit entry register (minutes, seconds-tens, seconds-units). Presents the value and a one-cycle active-low load strobe to the timer block.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (min 2).
CNT_W, 3, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
clearn  input  1  asynchronous active-low reset.
keypad  input  10  one-hot key lines; bit n = digit n.
entry_enable  input  1  1 = presses accepted (driven low by controller while magnetron runs).
entry_clr  input  1  synchronous clear of entry digits, e.g. stop while idle.
minutes  output  4  BCD minutes digit.
sec_tens  output  4  BCD seconds-tens digit.
sec_units  output  4  BCD seconds-units digit.
loadn  output  1  active-low one-cycle strobe; digits changed this cycle.
key_held  output  1  1 while an accepted key has not yet been released.

Behaviour:
- Reset (clearn=0, async): minutes=sec_tens=sec_units=0, loadn=1, key_held=0, FSM=IDLE, debounce counter=0, candidate code=0.
- Decode, combinational: exactly one bit set -> code 0..9, valid. Zero bits or more than one bit set -> "none". Multi-hot is treated as no key.
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
- IDLE: on a valid code, latch the candidate, set counter=1, go to PRESS_CHK.
- PRESS_CHK: same code -> counter+1. Different valid code -> reload the candidate, counter=1. "none" -> IDLE.
- Accept in PRESS_CHK: counter reaches DEBOUNCE_CYCLES with an unchanged code -> accept the press and go to HELD.
- Acceptance latency: DEBOUNCE_CYCLES clock edges after the first valid sample.
- On accept, if entry_enable=1:
  - next edge: minutes<=sec_tens, sec_tens<=sec_units, sec_units<=code.
  - loadn=0 for exactly that one cycle, coincident with the new values.
- On accept, if entry_enable=0: press consumed, digits unchanged, loadn stays 1, still go to HELD.
- key_held=1 in HELD and REL_CHK, 0 otherwise.
- HELD: "none" -> counter=1, go to REL_CHK. Any code, including a different key, is ignored; one accept per press.
- REL_CHK: "none" for DEBOUNCE_CYCLES consecutive samples -> IDLE. Any valid code -> back to HELD (bounce), no new accept.
- entry_clr=1: next edge clears all three digits to 0 and asserts loadn=0 for one cycle. The FSM is unaffected.
- entry_clr together with an accept on the same edge: clear wins; no shift happens; single loadn pulse.
- Digit values are not range-checked (sec_tens may be 6..9); the timer block owns normalisation.
- Oldest digit shifts out of minutes and is discarded; no overflow flag.
- Reset mid-press returns to IDLE immediately. A key still held after reset release must debounce from scratch and is accepted once.
- loadn is registered, never combinational; outputs are glitch-free.

Test Plan:
- Reset, then press 2, 5, 9, each held 110 cycles and released 110 cycles -> after the 3rd press minutes=2, sec_tens=5, sec_units=9; exactly 3 loadn pulses of 1 cycle each.
- Continue with 9, 9 -> minutes=9, sec_tens=9, sec_units=9; 5 loadn pulses total; 2 was discarded.
- Key 4 toggling every 2 cycles for 40 cycles (DEBOUNCE_CYCLES=4) -> no accept, loadn stays 1; held steady afterwards -> accepted once, sec_units=4.
- Hold key 7, glitch to 0 for 2 cycles mid-hold, then release -> single accept; key_held stays 1 through the glitch.
- keypad=10'b0000000110 for 50 cycles -> ignored, no loadn. entry_enable=0 then press 3 -> digits unchanged, no loadn, key_held=1 until release.
- entry_clr asserted on the same edge as the accept of key 8 with prior digits 1,2,3 -> all 0, one loadn pulse. clearn pulsed low mid-PRESS_CHK -> immediate zero outputs.

Source files
------------

// File: rtl/keypad_digit_entry_if.sv
// rtl/keypad_digit_entry_if.sv - keypad entry signals between the controller side and the entry block
interface keypad_digit_entry_if;
    logic [9:0] keypad;
    logic       entry_enable;
    logic       entry_clr;
    logic [3:0] minutes;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       loadn;
    logic       key_held;

    modport master (
        output keypad, entry_enable, entry_clr,
        input  minutes, sec_tens, sec_units, loadn, key_held
    );

    modport slave (
        input  keypad, entry_enable, entry_clr,
        output minutes, sec_tens, sec_units, loadn, key_held
    );
endinterface

// File: rtl/keypad_digit_entry.sv
// rtl/keypad_digit_entry.sv - debounced one-hot keypad to 3-digit BCD entry register with load strobe
module keypad_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 clearn,
    keypad_digit_entry_if.slave  kp
);
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cand_q;
    logic             key_held_q;

    logic [3:0] min_q,   min_d;
    logic [3:0] tens_q,  tens_d;
    logic [3:0] units_q, units_d;
    logic       loadn_q, loadn_d;

    logic [3:0] hot_cnt;
    logic [3:0] code;
    logic       code_valid;
    logic       accept;

    // Multi-hot and all-zero patterns both decode to "no key".
    always_comb begin
        hot_cnt = 4'd0;
        code    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (kp.keypad[i]) begin
                hot_cnt = hot_cnt + 4'd1;
                code    = 4'(i);
            end
        end
        code_valid = (hot_cnt == 4'd1);
    end

    assign accept = (state_q == PRESS_CHK) && code_valid && (code == cand_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'd0;
            key_held_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (code_valid) begin
                        cand_q  <= code;
                        cnt_q   <= CNT_ONE;
                        state_q <= PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (!code_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (code != cand_q) begin
                        cand_q <= code;
                        cnt_q  <= CNT_ONE;
                    end else if (accept) begin
                        cnt_q      <= '0;
                        key_held_q <= 1'b1;
                        state_q    <= HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    // Any key while held, even a different one, belongs to the same press.
                    if (!code_valid) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= REL_CHK;
                    end
                end
                REL_CHK: begin
                    if (code_valid) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q      <= '0;
                        key_held_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    key_held_q <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes priority over a simultaneous accept; either yields one load pulse.
    always_comb begin
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        loadn_d = 1'b1;
        if (kp.entry_clr) begin
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
            loadn_d = 1'b0;
        end else if (accept && kp.entry_enable) begin
            min_d   = tens_q;
            tens_d  = units_q;
            units_d = code;
            loadn_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            loadn_q <= 1'b1;
        end else begin
            min_q   <= min_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            loadn_q <= loadn_d;
        end
    end

    assign kp.minutes   = min_q;
    assign kp.sec_tens  = tens_q;
    assign kp.sec_units = units_q;
    assign kp.loadn     = loadn_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_digit_entry.sv
// tb/tb_keypad_digit_entry.sv - self-checking bench for keypad_digit_entry
module tb_keypad_digit_entry;
    localparam int N = 4;

    logic clk;
    logic clearn;
    int   checks;
    int   fails;
    int   pulses;

    keypad_digit_entry_if kp ();

    keypad_digit_entry #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .clk    (clk),
        .clearn (clearn),
        .kp     (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: run lengths of identical decoded samples plus three digit slots.
    int         m_run, m_last, m_nrun;
    bit         m_held;
    logic [3:0] m_dig [3];
    logic       m_loadn;

    function automatic int decode(input logic [9:0] k);
        if ($countones(k) != 1) return -1;
        for (int i = 0; i < 10; i++) if (k[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_last = -1; m_nrun = 0; m_held = 0;
        m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0; m_loadn = 1;
    endfunction

    function automatic void model_step(input logic [9:0] k, input logic en, input logic clr);
        int  c;
        bit  acc;
        c   = decode(k);
        acc = 0;
        if (!m_held) begin
            if (c >= 0) begin
                if (m_run > 0 && c == m_last) m_run++;
                else begin m_run = 1; m_last = c; end
                if (m_run == N) begin acc = 1; m_held = 1; m_run = 0; m_nrun = 0; end
            end else m_run = 0;
        end else begin
            if (c < 0) begin
                m_nrun++;
                if (m_nrun == N) begin m_held = 0; m_nrun = 0; end
            end else m_nrun = 0;
        end
        m_loadn = 1;
        if (clr) begin
            m_dig[0] = 0; m_dig[1] = 0; m_dig[2] = 0; m_loadn = 0;
        end else if (acc && en) begin
            m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = 4'(c); m_loadn = 0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic [13:0] act, exp;
        act = {kp.minutes, kp.sec_tens, kp.sec_units, kp.loadn, kp.key_held};
        exp = {m_dig[0], m_dig[1], m_dig[2], m_loadn, logic'(m_held)};
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model {min,tens,units,loadn,held}: got %h expected %h at %0t", act, exp, $time);
        end
    endtask

    task automatic step(input logic [9:0] k, input logic en, input logic clr);
        kp.keypad = k; kp.entry_enable = en; kp.entry_clr = clr;
        @(posedge clk);
        model_step(k, en, clr);
        #1;
        check_cycle();
        if (kp.loadn === 1'b0) pulses++;
    endtask

    task automatic hold(input logic [9:0] k, input logic en, input int n);
        for (int i = 0; i < n; i++) step(k, en, 1'b0);
    endtask

    task automatic check_digits(input string name, input int mi, input int te, input int un);
        check({name, " minutes"}, kp.minutes, mi);
        check({name, " sec_tens"}, kp.sec_tens, te);
        check({name, " sec_units"}, kp.sec_units, un);
    endtask

    typedef struct {
        logic [9:0] key;
        logic       en;
        int         hold_n;
        int         rel_n;
        logic       exp_held;
        int         exp_min;
        int         exp_tens;
        int         exp_units;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{10'b0000000100, 1'b1, 110, 110, 1'b1, 0, 0, 2, 1};
        vecs[1] = '{10'b0000100000, 1'b1, 110, 110, 1'b1, 0, 2, 5, 2};
        vecs[2] = '{10'b1000000000, 1'b1, 110, 110, 1'b1, 2, 5, 9, 3};
        vecs[3] = '{10'b1000000000, 1'b1, 110, 110, 1'b1, 5, 9, 9, 4};
        vecs[4] = '{10'b1000000000, 1'b1, 110, 110, 1'b1, 9, 9, 9, 5};
        vecs[5] = '{10'b0000000110, 1'b1,  50,  10, 1'b0, 9, 9, 9, 5};
        vecs[6] = '{10'b0000001000, 1'b0, 110, 110, 1'b1, 9, 9, 9, 5};

        checks = 0; fails = 0; pulses = 0;
        clearn = 1'b0;
        kp.keypad = '0; kp.entry_enable = 1'b1; kp.entry_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_digits("reset", 0, 0, 0);
        check("reset loadn", kp.loadn, 1);
        check("reset key_held", kp.key_held, 0);
        @(negedge clk) clearn = 1'b1;

        foreach (vecs[i]) begin
            hold(vecs[i].key, vecs[i].en, vecs[i].hold_n);
            check($sformatf("vec%0d key_held pressed", i), kp.key_held, vecs[i].exp_held);
            hold(10'b0, vecs[i].en, vecs[i].rel_n);
            check($sformatf("vec%0d key_held released", i), kp.key_held, 0);
            check_digits($sformatf("vec%0d", i), vecs[i].exp_min, vecs[i].exp_tens, vecs[i].exp_units);
            check($sformatf("vec%0d loadn pulses", i), pulses, vecs[i].exp_pulses);
        end

        // Key 4 chattering with period 4 never reaches 4 identical samples.
        for (int i = 0; i < 10; i++) begin
            hold(10'b0000010000, 1'b1, 2);
            hold(10'b0, 1'b1, 2);
        end
        check("chatter pulses", pulses, 5);
        hold(10'b0000010000, 1'b1, 20);
        hold(10'b0, 1'b1, 20);
        check_digits("chatter then steady", 9, 9, 4);
        check("chatter steady pulses", pulses, 6);

        hold(10'b0010000000, 1'b1, 20);
        for (int i = 0; i < 2; i++) begin
            step(10'b0, 1'b1, 1'b0);
            check("glitch key_held", kp.key_held, 1);
        end
        hold(10'b0010000000, 1'b1, 20);
        hold(10'b0, 1'b1, 20);
        check_digits("glitch", 9, 4, 7);
        check("glitch pulses", pulses, 7);

        step(10'b0, 1'b1, 1'b1);
        check_digits("entry_clr", 0, 0, 0);
        check("entry_clr loadn", kp.loadn, 0);
        step(10'b0, 1'b1, 1'b0);
        check("entry_clr loadn one cycle", kp.loadn, 1);
        hold(10'b0000000010, 1'b1, 10); hold(10'b0, 1'b1, 10);
        hold(10'b0000000100, 1'b1, 10); hold(10'b0, 1'b1, 10);
        hold(10'b0000001000, 1'b1, 10); hold(10'b0, 1'b1, 10);
        check_digits("prior 123", 1, 2, 3);
        pulses = 0;
        hold(10'b0100000000, 1'b1, N - 1);
        step(10'b0100000000, 1'b1, 1'b1);
        check_digits("clr with accept", 0, 0, 0);
        check("clr with accept loadn", kp.loadn, 0);
        hold(10'b0100000000, 1'b1, 10);
        hold(10'b0, 1'b1, 10);
        check("clr with accept pulses", pulses, 1);
        check_digits("clr with accept after", 0, 0, 0);

        hold(10'b0001000000, 1'b1, 10); hold(10'b0, 1'b1, 10);
        check_digits("before reset", 0, 0, 6);
        hold(10'b0000100000, 1'b1, 2);
        #2 clearn = 1'b0;
        #1;
        model_reset();
        check_digits("async reset", 0, 0, 0);
        check("async reset loadn", kp.loadn, 1);
        check("async reset key_held", kp.key_held, 0);
        @(negedge clk) clearn = 1'b1;
        pulses = 0;
        hold(10'b0000100000, 1'b1, 20);
        hold(10'b0, 1'b1, 20);
        check_digits("held through reset", 0, 0, 5);
        check("held through reset pulses", pulses, 1);

        for (int seg = 0; seg < 300; seg++) begin
            int         kind, len;
            logic [9:0] pat;
            logic       en;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 10);
            en   = ($urandom_range(0, 5) != 0);
            if (kind < 5) begin
                pat = '0;
                pat[$urandom_range(0, 9)] = 1'b1;
            end else if (kind < 8) begin
                pat = '0;
            end else begin
                pat = 10'($urandom);
            end
            for (int c = 0; c < len; c++)
                step(pat, en, ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
